// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary to 4-digit packed BCD converter with start/done handshake.
// bcd_out/overflow are only updated in LOAD so downstream sampling never sees scratch contents.
module bin_to_bcd_converter #(
    parameter int unsigned BIN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin_in,
    output logic [15:0]          bcd_out,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int unsigned EXT_W = BIN_WIDTH + 14;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [15:0]          scratch_q, scratch_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          bcd_q, bcd_d;
    logic                 overflow_q, overflow_d;
    logic                 done_q, done_d;
    logic [15:0]          adj;

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        adj = scratch_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d     = bin_in;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_WIDTH);
                    ovf_d     = ({14'b0, bin_in} > EXT_W'(9999));
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Bit leaving the top of the 16-bit scratch means the result cannot fit four digits.
                scratch_d = {adj[14:0], bin_q[BIN_WIDTH-1]};
                bin_d     = bin_q << 1;
                ovf_d     = ovf_q | adj[15];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                done_d = 1'b1;
                if (ovf_q) begin
                    bcd_d      = 16'h9999;
                    overflow_d = 1'b1;
                end else begin
                    bcd_d      = scratch_q;
                    overflow_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter: scoreboard of expected results plus per-scenario tasks.
module tb_bin_to_bcd_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin_in = 16'h0;
    logic [15:0] bcd_out;
    logic        busy;
    logic        done;
    logic        overflow;

    bin_to_bcd_converter #(.BIN_WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .bcd_out  (bcd_out),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int unsigned acc;
        int unsigned val;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    logic [15:0] prev_bcd = 16'h0;

    always @(posedge clk) cyc++;

    function automatic exp_t model(input int unsigned v, input int unsigned acc);
        exp_t e;
        e.val = v;
        e.acc = acc;
        if (v > 9999) begin
            e.bcd = 16'h9999;
            e.ovf = 1'b1;
        end else begin
            e.ovf = 1'b0;
            e.bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
        end
        return e;
    endfunction

    // Scoreboard: pops one expectation per done pulse and watches output stability.
    always @(negedge clk) begin
        if (!rst) begin
            prev_bcd = 16'h0;
        end else begin
            checks++;
            if (done === 1'b1 && busy === 1'b1) begin
                errors++;
                $display("FAIL busy_and_done: busy=%b done=%b required not both high (cyc %0d)", busy, done, cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no conversion pending (cyc %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    checks++;
                    if (bcd_out !== mon_e.bcd) begin
                        errors++;
                        $display("FAIL sb_bcd(%0d): got %h required %h", mon_e.val, bcd_out, mon_e.bcd);
                    end
                    checks++;
                    if (overflow !== mon_e.ovf) begin
                        errors++;
                        $display("FAIL sb_ovf(%0d): got %b required %b", mon_e.val, overflow, mon_e.ovf);
                    end
                    checks++;
                    if (cyc - mon_e.acc != 17) begin
                        errors++;
                        $display("FAIL sb_latency(%0d): got %0d required 17", mon_e.val, cyc - mon_e.acc);
                    end
                end
            end else begin
                checks++;
                if (bcd_out !== prev_bcd) begin
                    errors++;
                    $display("FAIL bcd_stable: got %h required %h (no done, cyc %0d)", bcd_out, prev_bcd, cyc);
                end
            end
            prev_bcd = bcd_out;
        end
    end

    task automatic do_conv(input int unsigned v, output bit found, output int unsigned lat);
        int unsigned acc;
        found = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'(v);
        acc    = cyc + 1;
        q.push_back(model(v, acc));
        @(negedge clk);
        start  = 1'b0;
        bin_in = 16'($urandom);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
            bin_in = 16'($urandom);
        end
        lat = cyc - acc;
        #1;
    endtask

    task automatic test_reset();
        bit rose;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bcd_out, busy, done, overflow} !== 19'h0) begin
            errors++;
            $display("FAIL reset_values: bcd=%h busy=%b done=%b ovf=%b required all 0", bcd_out, busy, done, overflow);
        end
        rst  = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0 || overflow !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose) begin
            errors++;
            $display("FAIL idle_quiet: got activity after reset without start, required none");
        end
    endtask

    task automatic test_nominal();
        bit found;
        int unsigned lat;
        do_conv(1234, found, lat);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL nominal_timeout: no done within 40 cycles");
        end
        checks++;
        if (lat != 17) begin
            errors++;
            $display("FAIL nominal_latency: got %0d required 17", lat);
        end
        checks++;
        if (bcd_out !== 16'h1234 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL nominal_value: got %h ovf=%b required 1234 ovf=0", bcd_out, overflow);
        end
    endtask

    task automatic test_boundaries();
        int unsigned vals[4]  = '{0, 9999, 10000, 65535};
        logic [15:0] ebcd[4]  = '{16'h0000, 16'h9999, 16'h9999, 16'h9999};
        logic        eovf[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        bit found;
        int unsigned lat;
        for (int i = 0; i < 4; i++) begin
            do_conv(vals[i], found, lat);
            checks++;
            if (!found || bcd_out !== ebcd[i] || overflow !== eovf[i]) begin
                errors++;
                $display("FAIL boundary(%0d): done=%b bcd=%h ovf=%b required done bcd=%h ovf=%b",
                         vals[i], found, bcd_out, overflow, ebcd[i], eovf[i]);
            end
        end
    endtask

    task automatic test_random();
        bit found;
        int unsigned lat;
        int unsigned v;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            v = (i < 4) ? $urandom_range(0, 9999) : $urandom_range(10000, 65535);
            e = model(v, 0);
            do_conv(v, found, lat);
            checks++;
            if (!found || bcd_out !== e.bcd || overflow !== e.ovf) begin
                errors++;
                $display("FAIL random(%0d): done=%b bcd=%h ovf=%b required bcd=%h ovf=%b",
                         v, found, bcd_out, overflow, e.bcd, e.ovf);
            end
        end
    endtask

    task automatic test_ignored_start();
        bit found;
        int unsigned acc;
        int unsigned r;
        int unsigned n0;
        found = 1'b0;
        n0 = done_cnt;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd42;
        acc    = cyc + 1;
        q.push_back(model(42, acc));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            r      = cyc - acc;
            start  = (r == 5 || r == 16);
            bin_in = 16'd777;
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        start = 1'b0;
        #1;
        checks++;
        if (!found || bcd_out !== 16'h0042) begin
            errors++;
            $display("FAIL ignored_start_value: done=%b bcd=%h required done bcd=0042", found, bcd_out);
        end
        repeat (25) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != n0 + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_single: done count %0d busy=%b required 1 busy=0", done_cnt - n0, busy);
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        int unsigned d1;
        int unsigned d2;
        d1 = 0;
        d2 = 0;
        found = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd58;
        q.push_back(model(58, cyc + 1));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        d1 = cyc;
        checks++;
        if (!found || bcd_out !== 16'h0058) begin
            errors++;
            $display("FAIL b2b_first: done=%b bcd=%h required done bcd=0058", found, bcd_out);
        end
        bin_in = 16'd8061;
        q.push_back(model(8061, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        d2 = cyc;
        #1;
        checks++;
        if (!found || bcd_out !== 16'h8061) begin
            errors++;
            $display("FAIL b2b_second: done=%b bcd=%h required done bcd=8061", found, bcd_out);
        end
        checks++;
        if (d2 - d1 != 18) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles required 18", d2 - d1);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int unsigned lat;
        int unsigned n0;
        do_conv(4321, found, lat);
        checks++;
        if (!found || bcd_out !== 16'h4321) begin
            errors++;
            $display("FAIL rst_mid_pre: done=%b bcd=%h required done bcd=4321", found, bcd_out);
        end
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd9876;
        q.push_back(model(9876, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        q.delete();
        #1;
        checks++;
        if (bcd_out !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_immediate: bcd=%h busy=%b done=%b ovf=%b required all 0", bcd_out, busy, done, overflow);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n0 = done_cnt;
        repeat (25) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != n0 || bcd_out !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_no_done: done count %0d bcd=%h required 0 and 0000", done_cnt - n0, bcd_out);
        end
        do_conv(9876, found, lat);
        checks++;
        if (!found || bcd_out !== 16'h9876) begin
            errors++;
            $display("FAIL rst_mid_fresh: done=%b bcd=%h required done bcd=9876", found, bcd_out);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_boundaries();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected results never produced, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_converter.md
# bin_to_bcd_converter

Sequential double-dabble converter that turns an unsigned binary count into four packed BCD digits. It is the stage directly upstream of the 4-digit seven-segment multiplexer: its `bcd_out` drives the display's 16-bit `binary_input`, so each nibble shows a decimal digit 0–9 instead of a hex value. Conversion is start/done handshaked and the last result is held stably between conversions, so the display never sees intermediate shift-register contents.

## Interface
- `BIN_WIDTH`, default 16: width of the binary input; also the number of shift iterations.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-low; asserting it (low) immediately forces all state and outputs to reset values.
- `start` input 1: request a conversion of `bin_in`; sampled only in IDLE.
- `bin_in` input BIN_WIDTH: unsigned value to convert; captured on the edge that accepts `start`.
- `bcd_out` output 16: packed BCD, `[3:0]` ones, `[7:4]` tens, `[11:8]` hundreds, `[15:12]` thousands; registered, held until the next completed conversion.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: single-cycle pulse when `bcd_out` has just been updated.
- `overflow` output 1: valid with `done` and held until the next `done`; high when the captured value exceeded 9999.

## Operation
- States: IDLE, SHIFT, LOAD.
- IDLE, `start`=1 at an edge:
  - Capture `bin_in` into the binary shift register.
  - Clear the 16-bit BCD scratch register and load the iteration counter with BIN_WIDTH.
  - Go to SHIFT and set `busy`=1.
- IDLE, `start`=0: no action.
- SHIFT, one iteration per clock:
  - For each scratch nibble ≥5, add 3 to that nibble.
  - Shift {scratch, binary} left by 1.
  - Decrement the counter.
  - After the BIN_WIDTH-th iteration, go to LOAD.
- The BCD scratch register is 16 bits wide. Any bit shifted out of the top is dropped and sets an internal sticky overflow flag, which is cleared on capture.
- The overflow flag is also set when the captured value is greater than 9999; this compare is made at capture time.
- LOAD, one clock, then return to IDLE:
  - If the overflow flag is set: `bcd_out`=16'h9999 and `overflow`=1.
  - Otherwise: `bcd_out`=scratch and `overflow`=0.
  - `done`=1 for this cycle, `busy`=0.
- `start` is ignored while in SHIFT or LOAD; no queuing.
- BIN_WIDTH < 14 never overflows. The iteration counter is sized for BIN_WIDTH.

## Timing
- Reset values: `bcd_out`=16'h0000, `busy`=0, `done`=0, `overflow`=0, state IDLE.
- Latency: `start` is accepted at edge E0. `done` is high in the cycle following edge E(BIN_WIDTH+1), which is E17 at the default width. `bcd_out` changes on that same edge.
- `busy` is high from after E0 until `done` rises; `busy` and `done` are never high together.
- Throughput: one conversion per BIN_WIDTH+2 cycles. A `start` held high during the `done` cycle is accepted at the next edge, giving back-to-back conversions.
- `bcd_out` and `overflow` change only on a `done` edge or on reset.
- Reset mid-conversion: the conversion is aborted, no `done` is generated, and `bcd_out` returns to 0.
- The downstream multiplexer samples `bcd_out` asynchronously to conversions. Stability is guaranteed because `bcd_out` updates only in LOAD.

## Test plan
- Reset then idle: `rst` low for 3 cycles, then high; no `start` → all outputs 0 indefinitely; `busy` never rises.
- Nominal: `bin_in`=1234, pulse `start` → `done` pulse exactly 17 cycles after the accepting edge; `bcd_out`=16'h1234; `overflow`=0.
- Boundaries:
  - `bin_in`=0 → 16'h0000.
  - `bin_in`=9999 → 16'h9999 with `overflow`=0.
  - `bin_in`=10000 → 16'h9999 with `overflow`=1.
  - `bin_in`=65535 → 16'h9999 with `overflow`=1.
- Ignored start and input hold:
  - Start 42; pulse `start` with `bin_in`=777 on cycles 5 and 16 → single `done`, `bcd_out`=16'h0042.
  - Change `bin_in` mid-conversion → result unaffected.
- Back-to-back: hold `start` high with `bin_in`=58, then 8061 → `done` pulses 18 cycles apart; `bcd_out`=16'h0058, then 16'h8061; `bcd_out` constant between pulses.
- Reset mid-operation: complete 4321; start 9876, assert `rst` at cycle 8 → `bcd_out`=0 immediately, no `done`; a fresh start of 9876 yields 16'h9876.
